// File: rtl/spi_config_regs_if.sv
// SPI bus bundle for the configuration register slave.
// The master modport drives the bus and the slave modport only observes it.
interface spi_config_regs_if;
  logic sclk;
  logic copi;
  logic ncs;

  modport master (output sclk, output copi, output ncs);
  modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_config_regs.sv
// Write-only SPI mode-0 slave that loads the five PWM configuration registers.
// SCLK, COPI and nCS are oversampled in the clk domain; a frame is committed only on a clean 16-bit write.
module spi_config_regs #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_config_regs_if.slave   spi,
  output logic [7:0]         en_reg_out_7_0,
  output logic [7:0]         en_reg_out_15_8,
  output logic [7:0]         en_reg_pwm_7_0,
  output logic [7:0]         en_reg_pwm_15_8,
  output logic [7:0]         pwm_duty_cycle,
  output logic               frame_ok
);

  localparam int          NUM_REGS   = 5;
  localparam logic [6:0]  MAX_ADDR_L = 7'(MAX_ADDR);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic                   sclk_prev, ncs_prev;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_fall, ncs_rise;

  state_t       state_reg, state_next;
  logic [4:0]   count_reg, count_next;
  logic [15:0]  shift_reg, shift_next;
  logic         ovf_reg, ovf_next;
  logic         commit_ok;
  logic [6:0]   addr;
  logic [NUM_REGS-1:0] wr_en;
  logic [7:0]   cfg_regs [0:NUM_REGS-1];

  // Synchronizers reset to the idle bus levels so release does not fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_prev <= 1'b0;
      ncs_prev  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0],  spi.ncs};
      sclk_prev <= sclk_s;
      ncs_prev  <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign ncs_fall  = ~ncs_s & ncs_prev;
  assign ncs_rise  = ncs_s & ~ncs_prev;
  assign addr      = shift_reg[14:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      shift_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      shift_reg <= shift_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    shift_next = shift_reg;
    ovf_next   = ovf_reg;
    commit_ok  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ncs_fall) begin
          count_next = '0;
          shift_next = '0;
          ovf_next   = 1'b0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_next = {shift_reg[14:0], copi_s};
          if (count_reg == 5'd16) ovf_next = 1'b1;
          if (count_reg != 5'd17) count_next = count_reg + 5'd1;
        end
        if (ncs_rise) state_next = COMMIT;
      end
      COMMIT: begin
        commit_ok  = (count_reg == 5'd16) && !ovf_reg && shift_reg[15] && (addr <= MAX_ADDR_L);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_wr_dec
      assign wr_en[gi] = commit_ok && (addr == 7'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) cfg_regs[i] <= 8'h00;
      frame_ok <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_en[i]) cfg_regs[i] <= shift_reg[7:0];
      frame_ok <= commit_ok;
    end
  end

  assign en_reg_out_7_0  = cfg_regs[0];
  assign en_reg_out_15_8 = cfg_regs[1];
  assign en_reg_pwm_7_0  = cfg_regs[2];
  assign en_reg_pwm_15_8 = cfg_regs[3];
  assign pwm_duty_cycle  = cfg_regs[4];

endmodule

// File: tb/tb_spi_config_regs.sv
// Directed bench for spi_config_regs: drives SPI frames bit by bit and checks registers and frame_ok.
module tb_spi_config_regs;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       frame_ok;

  spi_config_regs_if spi();

  spi_config_regs #(.SYNC_STAGES(SYNC), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .spi             (spi),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .frame_ok        (frame_ok)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int ok_count = 0;
  int ok_cyc = 0;
  int rise_cyc = 0;
  logic [7:0] exp_r [0:4];

  always @(posedge clk) cyc++;
  always @(negedge clk) if (frame_ok === 1'b1) begin ok_count++; ok_cyc = cyc; end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".out_7_0"},  {24'd0, en_reg_out_7_0},  {24'd0, exp_r[0]});
    check({tag, ".out_15_8"}, {24'd0, en_reg_out_15_8}, {24'd0, exp_r[1]});
    check({tag, ".pwm_7_0"},  {24'd0, en_reg_pwm_7_0},  {24'd0, exp_r[2]});
    check({tag, ".pwm_15_8"}, {24'd0, en_reg_pwm_15_8}, {24'd0, exp_r[3]});
    check({tag, ".duty"},     {24'd0, pwm_duty_cycle},  {24'd0, exp_r[4]});
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi.copi = bits[i];
      clk_wait(4);
      spi.sclk = 1'b1;
      clk_wait(4);
      spi.sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] bits, input int nbits, input int gap);
    spi.ncs = 1'b0;
    clk_wait(2);
    send_bits(bits, nbits);
    clk_wait(2);
    spi.ncs  = 1'b1;
    rise_cyc = cyc;
    clk_wait(gap);
  endtask

  task automatic expect_frame(input string tag, input logic [31:0] bits, input int nbits, input bit ok);
    int n0;
    n0 = ok_count;
    send_frame(bits, nbits, 10);
    $display("frame %s: bits=%0h nbits=%0d frame_ok pulses=%0d", tag, bits, nbits, ok_count - n0);
    check({tag, ".pulses"}, 32'(ok_count - n0), ok ? 32'd1 : 32'd0);
    if (ok) check({tag, ".latency"}, 32'(ok_cyc - rise_cyc), 32'(LAT));
  endtask

  initial begin
    int n0;
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    spi.ncs  = 1'b1;
    for (int i = 0; i < 5; i++) exp_r[i] = 8'h00;
    rst_n = 1'b0;
    clk_wait(3);
    rst_n = 1'b1;
    clk_wait(2);
    check_regs("reset");
    check("reset.frame_ok", {31'd0, frame_ok}, 32'd0);

    expect_frame("w0_ff", 32'h80FF, 16, 1'b1);
    exp_r[0] = 8'hFF;
    check_regs("w0_ff");

    expect_frame("w1_a5", 32'h81A5, 16, 1'b1);
    expect_frame("w2_3c", 32'h823C, 16, 1'b1);
    expect_frame("w3_0f", 32'h830F, 16, 1'b1);
    expect_frame("w4_80", 32'h8480, 16, 1'b1);
    exp_r[1] = 8'hA5; exp_r[2] = 8'h3C; exp_r[3] = 8'h0F; exp_r[4] = 8'h80;
    check_regs("w1_4");
    for (int i = 0; i < 5; i++)
      check($sformatf("hier_reg%0d", i), {24'd0, dut.cfg_regs[i]}, {24'd0, exp_r[i]});

    expect_frame("read0", 32'h0055, 16, 1'b0);
    expect_frame("addr5", 32'h8522, 16, 1'b0);
    check_regs("no_write");

    expect_frame("short15", 32'h40A1, 15, 1'b0);
    expect_frame("long17", 32'h10284, 17, 1'b0);
    check_regs("bad_len");
    expect_frame("w1_42", 32'h8142, 16, 1'b1);
    exp_r[1] = 8'h42;
    check_regs("w1_42");

    for (int i = 0; i < 16; i++) begin
      spi.copi = 1'b1;
      clk_wait(4);
      spi.sclk = 1'b1;
      clk_wait(4);
      spi.sclk = 1'b0;
    end
    clk_wait(4);
    check_regs("sclk_ncs_high");
    expect_frame("w4_33", 32'h8433, 16, 1'b1);
    exp_r[4] = 8'h33;
    check_regs("w4_33");

    n0 = ok_count;
    send_frame(32'h8201, 16, 3);
    send_frame(32'h8302, 16, 10);
    $display("back_to_back: frame_ok pulses=%0d", ok_count - n0);
    check("b2b.pulses", 32'(ok_count - n0), 32'd2);
    exp_r[2] = 8'h01; exp_r[3] = 8'h02;
    check_regs("b2b");

    spi.ncs = 1'b0;
    clk_wait(2);
    send_bits(32'h84, 8);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) exp_r[i] = 8'h00;
    $display("mid-frame reset asserted");
    check_regs("async_rst");
    check("async_rst.frame_ok", {31'd0, frame_ok}, 32'd0);
    spi.ncs  = 1'b1;
    spi.copi = 1'b0;
    clk_wait(3);
    rst_n = 1'b1;
    clk_wait(3);
    expect_frame("w4_10", 32'h8410, 16, 1'b1);
    exp_r[4] = 8'h10;
    check_regs("after_rst");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/spi_config_regs.md
Name: spi_config_regs

Overview:
- SPI-slave register file that configures the PWM peripheral from the chip's dedicated inputs.
- Receives write-only SPI mode-0 frames (SCLK, COPI, nCS on ui_in[0..2]) and drives the five PWM configuration registers: output enables, PWM enables and duty cycle.
- Sits in the top level between ui_in and pwm_peripheral, in the clk domain; SCLK is asynchronous and oversampled.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on each of sclk, copi, ncs (minimum 2).
- MAX_ADDR, 4, highest valid register address; frames addressing above it are discarded.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sclk  input  1  SPI clock, asynchronous to clk, idle low.
- copi  input  1  SPI data in, MSB first.
- ncs  input  1  SPI chip select, active low, asynchronous.
- en_reg_out_7_0  output  8  register 0x00, output enables for out[7:0].
- en_reg_out_15_8  output  8  register 0x01, output enables for out[15:8].
- en_reg_pwm_7_0  output  8  register 0x02, PWM mode enables for out[7:0].
- en_reg_pwm_15_8  output  8  register 0x03, PWM mode enables for out[15:8].
- pwm_duty_cycle  output  8  register 0x04, shared duty cycle.
- frame_ok  output  1  one-clk pulse when a frame is committed to a register.

Behaviour:
- Reset (async assert, sync release): all five registers = 8'h00, frame_ok = 0, shift register and counter cleared, state IDLE, overflow flag cleared, synchronizer flops set to idle values (sclk=0, copi=0, ncs=1).
- Synchronizers: sclk, copi and ncs each pass through SYNC_STAGES flops, plus one history flop for sclk and ncs. Edges are detected on the synchronized signals only.
- Timing: sclk high and low phases must each be ≥ 3 clk periods.
- Frame format: 16 bits, MSB first. Bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- States:
  - IDLE: wait for synced ncs falling edge, then clear the 5-bit bit counter, the shift register and the overflow flag, and go to SHIFT.
  - SHIFT: on each synced sclk rising edge, shift synced copi into the LSB and increment the counter, saturating at 17. Set the overflow flag when a 17th edge arrives. On synced ncs rising edge, go to COMMIT.
  - COMMIT (one cycle):
    - If counter == 16, no overflow, bit15 == 1 and address ≤ MAX_ADDR: write data to the addressed register and pulse frame_ok.
    - Otherwise discard silently.
    - Always return to IDLE.
- Latency: a committed register changes exactly SYNC_STAGES+2 clk rising edges after the first clk edge that samples raw ncs high. frame_ok is high in that same cycle.
- sclk edges while synced ncs is high are ignored.
- Reads (bit15 = 0) modify nothing. No read-back; there is no CIPO.
- Short frames (< 16 bits) and long frames (> 16 bits) are discarded. Registers not addressed by a committed frame hold their value.
- Back-to-back frames: a new ncs falling edge in the cycle after COMMIT must be accepted.
- Reset mid-frame: the partial frame is lost and registers go to 0. If ncs is low at reset release, its synchronizer resets to 1, which creates a falling edge. The bench must therefore keep ncs high across reset release; any frame in progress at release is not guaranteed.
- Outputs are registered; no combinational path exists from inputs to outputs.

Test Plan:
- Reset → all five registers 0x00, frame_ok 0. Write frame 0x80FF (addr 0, data 0xFF) → en_reg_out_7_0 = 0xFF within 4 clk of ncs rising, one frame_ok pulse; the other registers stay 0x00.
- Write addresses 0x01..0x04 with 0xA5, 0x3C, 0x0F, 0x80 → each register holds its value; a readback of all five via hierarchy matches.
- Read frame 0x0055 to addr 0 and write frame 0x8522 to addr 5 → no register changes, no frame_ok.
- 15-bit frame and 17-bit frame carrying 0x8142 prefix → en_reg_out_15_8 unchanged, no frame_ok. A following correct 0x8142 frame → en_reg_out_15_8 = 0x42.
- sclk toggled 16 times with ncs high, then a valid frame 0x8433 → only pwm_duty_cycle = 0x33. Two back-to-back frames 0x8201 and 0x8302 with ncs high for 3 clk → both committed.
- rst_n asserted mid-frame after 8 bits of 0x84FF → registers 0x00 immediately (asynchronous). After release, a clean frame 0x8410 → pwm_duty_cycle = 0x10.
